// File: rtl/brq_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : brq_div_ctrl (with package brq_div_pkg)
//  Description : Multi-cycle restoring radix-2 divider for DIV/REM requests.
//                Signed operands are converted to magnitudes on accept.
//                The sign of the result is corrected when it is delivered.
//                Divide-by-zero skips the iteration loop entirely.
//  Revision    : 1.0 - initial release
// ============================================================================

package brq_div_pkg;
    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;
endpackage

module brq_div_ctrl
    import brq_div_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  md_op_e           op_i,
    input  logic             signed_i,
    input  logic [Width-1:0] op_a_i,
    input  logic [Width-1:0] op_b_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] result_o,
    output logic             busy_o
);

    localparam int CNT_W = (Width > 1) ? $clog2(Width) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             r_state;
    md_op_e             r_op;
    logic               r_signed;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [CNT_W-1:0]   r_cnt;
    logic [Width:0]     r_rem;     // one spare bit so the compare below never overflows
    logic [Width-1:0]   r_quo;     // holds the dividend magnitude, shifted out as quotient shifts in
    logic [Width-1:0]   r_div;
    logic [Width-1:0]   r_result;

    logic               w_accept;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [Width-1:0]   w_mag_a;
    logic [Width-1:0]   w_mag_b;
    logic [Width+1:0]   w_shift;
    logic               w_ge;
    logic [Width:0]     w_rem_step;
    logic [Width-1:0]   w_quo_step;
    logic [Width-1:0]   w_quo_fin;
    logic [Width-1:0]   w_rem_fin;
    logic [Width-1:0]   w_result_fin;

    // Only divide-type operations are ever taken; a kill blocks the accept.
    assign w_accept = (r_state == IDLE) && valid_i && !kill_i &&
                      ((op_i == MD_OP_DIV) || (op_i == MD_OP_REM));

    assign w_neg_a  = signed_i && op_a_i[Width-1];
    assign w_neg_b  = signed_i && op_b_i[Width-1];
    assign w_mag_a  = w_neg_a ? -op_a_i : op_a_i;
    assign w_mag_b  = w_neg_b ? -op_b_i : op_b_i;

    // One restoring step: shift {rem, quo} left, subtract if it fits.
    always_comb begin
        w_shift    = {r_rem, r_quo[Width-1]};
        w_ge       = (w_shift >= {2'b00, r_div});
        w_rem_step = w_ge ? (w_shift[Width:0] - {1'b0, r_div}) : w_shift[Width:0];
        w_quo_step = {r_quo[Width-2:0], w_ge};
    end

    // Sign correction applied to the outcome of the final step.
    always_comb begin
        w_quo_fin    = (r_signed && (r_sign_a ^ r_sign_b)) ? -w_quo_step : w_quo_step;
        w_rem_fin    = (r_signed && r_sign_a) ? -w_rem_step[Width-1:0] : w_rem_step[Width-1:0];
        w_result_fin = (r_op == MD_OP_DIV) ? w_quo_fin : w_rem_fin;
    end

    // Control FSM and datapath registers; the result register is zero outside DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_op     <= MD_OP_MULL;
            r_signed <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op     <= op_i;
                        r_signed <= signed_i;
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        if (op_b_i == '0) begin
                            r_state  <= DONE;
                            r_result <= (op_i == MD_OP_DIV) ? '1 : op_a_i;
                        end else begin
                            r_state <= CALC;
                            r_rem   <= '0;
                            r_quo   <= w_mag_a;
                            r_div   <= w_mag_b;
                            r_cnt   <= CNT_W'(Width - 1);
                        end
                    end
                end
                CALC: begin
                    if (kill_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_rem <= w_rem_step;
                        r_quo <= w_quo_step;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == '0) begin
                            r_state  <= DONE;
                            r_result <= w_result_fin;
                        end
                    end
                end
                DONE: begin
                    if (kill_i || ready_i) begin
                        r_state  <= IDLE;
                        r_result <= '0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_result <= '0;
                end
            endcase
        end
    end

    assign ready_o  = (r_state == IDLE);
    assign busy_o   = (r_state != IDLE);
    assign valid_o  = (r_state == DONE);
    assign result_o = r_result;

endmodule

`default_nettype wire

// File: tb/tb_brq_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brq_div_ctrl
//  Description : Directed self-checking bench for brq_div_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brq_div_ctrl;
    import brq_div_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    md_op_e      op_i;
    logic        signed_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        busy_o;

    int n_checks;
    int n_pass;

    brq_div_ctrl #(.Width(32)) u_dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .signed_i (signed_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Present one request for a single edge; called at posedge+1.
    task automatic issue(input md_op_e op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        valid_i  = 1'b1;
        op_i     = op;
        signed_i = sgn;
        op_a_i   = a;
        op_b_i   = b;
        @(posedge clk); #1;
        valid_i  = 1'b0;
    endtask

    // Cycles from the accept edge until valid_o (bounded).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_result(input string tag);
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        check({tag, "_released"}, {31'd0, valid_o}, 32'd0);
    endtask

    task automatic run_op(input string tag, input md_op_e op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        issue(op, sgn, a, b);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result_o, exp_res);
        take_result(tag);
    endtask

    // Count valid_o pulses over a window of cycles.
    task automatic count_valid(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (valid_o) hits++;
        end
    endtask

    initial begin
        int lat;
        int hits;
        int unstable;
        logic [31:0] held;

        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        valid_i  = 1'b0;
        op_i     = MD_OP_DIV;
        signed_i = 1'b0;
        op_a_i   = '0;
        op_b_i   = '0;
        kill_i   = 1'b0;
        ready_i  = 1'b0;

        #12;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_busy",  {31'd0, busy_o},  32'd0);
        check("rst_result", result_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("udiv",  MD_OP_DIV, 1'b0, 32'd100, 32'd7, 32'd14, 33);
        run_op("urem",  MD_OP_REM, 1'b0, 32'd100, 32'd7, 32'd2,  33);
        run_op("sdiv",  MD_OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("srem",  MD_OP_REM, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div0",  MD_OP_DIV, 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem0",  MD_OP_REM, 1'b0, 32'd5, 32'd0, 32'd5, 1);
        run_op("sdiv0", MD_OP_DIV, 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("ovf_div", MD_OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_op("ovf_rem", MD_OP_REM, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run_op("srem_pos", MD_OP_REM, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);

        // Multiply opcodes must be ignored.
        issue(MD_OP_MULL, 1'b0, 32'd9, 32'd3);
        check("mull_ignored", {31'd0, busy_o}, 32'd0);
        issue(MD_OP_MULH, 1'b0, 32'd9, 32'd3);
        check("mulh_ignored", {31'd0, busy_o}, 32'd0);

        // Kill at CALC cycle 10, then a fresh request.
        issue(MD_OP_DIV, 1'b0, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        check("kill_busy_before", {31'd0, busy_o}, 32'd1);
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        check("kill_idle", {31'd0, ready_o}, 32'd1);
        count_valid(40, hits);
        check("kill_no_valid", 32'(hits), 32'd0);
        run_op("after_kill", MD_OP_DIV, 1'b0, 32'd20, 32'd4, 32'd5, 33);

        // Back-pressure: result held while ready_i is low; no accept on the release edge.
        issue(MD_OP_DIV, 1'b0, 32'd1000, 32'd3);
        wait_valid(lat);
        check("bp_res", result_o, 32'd333);
        held     = result_o;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (!valid_o || result_o !== held) unstable++;
        end
        check("bp_stable", 32'(unstable), 32'd0);
        ready_i  = 1'b1;
        valid_i  = 1'b1;
        op_i     = MD_OP_DIV;
        op_a_i   = 32'd50;
        op_b_i   = 32'd5;
        @(posedge clk); #1;
        ready_i  = 1'b0;
        valid_i  = 1'b0;
        check("bp_no_accept_busy", {31'd0, busy_o}, 32'd0);
        check("bp_no_accept_res", result_o, 32'd0);

        // Kill while in DONE suppresses the result.
        issue(MD_OP_REM, 1'b0, 32'd1000, 32'd3);
        wait_valid(lat);
        check("kdone_res", result_o, 32'd1);
        kill_i  = 1'b1;
        ready_i = 1'b0;
        @(posedge clk); #1;
        kill_i  = 1'b0;
        check("kdone_valid", {31'd0, valid_o}, 32'd0);
        check("kdone_result", result_o, 32'd0);

        // Reset in the middle of CALC discards the operation.
        issue(MD_OP_DIV, 1'b0, 32'd77, 32'd7);
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("mrst_ready",  {31'd0, ready_o}, 32'd1);
        check("mrst_valid",  {31'd0, valid_o}, 32'd0);
        check("mrst_busy",   {31'd0, busy_o},  32'd0);
        check("mrst_result", result_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_valid(40, hits);
        check("mrst_no_valid", 32'(hits), 32'd0);
        run_op("after_rst", MD_OP_REM, 1'b0, 32'd77, 32'd10, 32'd7, 33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/brq_div_ctrl.md
BRQ_DIV_CTRL -- requirements
Module: brq_div_ctrl

Interface
REQ-001 SHALL have parameter Width, default 32: operand/result width and iteration count.
REQ-002 SHALL have port clk_i  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port valid_i  input  1  request valid.
REQ-005 SHALL have port ready_o  output  1  request can be accepted.
REQ-006 SHALL have port op_i  input  md_op_e (2)  MD_OP_DIV or MD_OP_REM.
REQ-007 SHALL have port signed_i  input  1  operands are two's complement when 1.
REQ-008 SHALL have port op_a_i  input  Width  dividend.
REQ-009 SHALL have port op_b_i  input  Width  divisor.
REQ-010 SHALL have port kill_i  input  1  pipeline flush, abort current operation.
REQ-011 SHALL have port valid_o  output  1  result valid.
REQ-012 SHALL have port ready_i  input  1  consumer takes result.
REQ-013 SHALL have port result_o  output  Width  quotient (DIV) or remainder (REM).
REQ-014 SHALL have port busy_o  output  1  state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; ready_o = (state == IDLE); busy_o = (state != IDLE).
REQ-016 Accept SHALL occur on an edge where state = IDLE, valid_i = 1, op_i in {MD_OP_DIV, MD_OP_REM}, kill_i = 0; op_i, signed_i, and operand signs SHALL be latched then.
REQ-017 Requests with op_i = MD_OP_MULL or MD_OP_MULH SHALL never be accepted; state remains IDLE.
REQ-018 On accept with op_b_i != 0: |op_a_i| and |op_b_i| latched as unsigned magnitudes (signed_i = 1 uses two's-complement negation when MSB set), iteration counter loaded with Width-1, next state CALC.
REQ-019 On accept with op_b_i == 0: next state DONE directly; result DIV = all ones, REM = op_a_i unchanged, for both signed and unsigned.
REQ-020 CALC SHALL perform one restoring radix-2 step per cycle: shift {remainder, quotient} left 1, subtract divisor from remainder when remainder >= divisor and set quotient LSB to 1, otherwise set it to 0.
REQ-021 Remainder register SHALL be Width+1 bits so the compare never overflows; the counter decrements each CALC cycle; CALC->DONE after the step with counter = 0 (exactly Width steps).
REQ-022 Signed correction in DONE: quotient negated iff signed and sign(a) XOR sign(b); remainder negated iff signed and sign(a); result_o selected by latched op.
REQ-023 Overflow case signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0 through the normal datapath, with no special path.
REQ-024 Latency: valid_o high Width+1 cycles after the accept cycle (33 at Width = 32); divide-by-zero: 1 cycle after accept.
REQ-025 valid_o = (state == DONE); result_o SHALL be held stable while valid_o = 1 and ready_i = 0.
REQ-026 DONE->IDLE on an edge with ready_i = 1; a new request SHALL NOT be accepted in that same cycle (ready_o = 0 in DONE).
REQ-027 kill_i = 1 in CALC or DONE SHALL force next state IDLE with no valid_o pulse; kill_i has priority over ready_i and over accept.
REQ-028 result_o SHALL read 0 whenever valid_o = 0.

Reset
REQ-029 On rst_ni low, asynchronously: state IDLE, counter 0, all datapath registers 0; outputs ready_o = 1, valid_o = 0, busy_o = 0, result_o = 0.
REQ-030 Reset asserted during CALC or DONE SHALL discard the operation; after release no valid_o occurs until a new accept.

Verification
REQ-031 Unsigned DIV 100/7 -> valid_o at cycle 33 after accept, result_o = 14; REM -> 2.
REQ-032 Signed DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-033 DIV 0x1234/0 -> 0xFFFFFFFF one cycle after accept; REM 5/0 -> 5.
REQ-034 Signed DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; latency 33.
REQ-035 kill_i pulsed at CALC cycle 10 -> IDLE next cycle, no valid_o; the next request (20/4) returns 5.
REQ-036 ready_i held low 5 cycles in DONE -> valid_o and result_o stable; rst_ni pulsed mid-CALC -> all outputs at reset values, no result.
